// File: rtl/timeout_arbiter_pkg.sv
// Shared types and helpers for the timeout arbiter.
//   state_e   : arbiter FSM states
//   idx_width : index width for a requester count, never below 1
package timeout_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefaultNumReq = 4;
  localparam int unsigned DefaultIdxW   = idx_width(DefaultNumReq);

endpackage

// File: rtl/timeout_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : highest-priority index
//   valid_o  : some request is set
//   idx_o    : first set index at or after ptr_i, wrapping
//   onehot_o : one-hot form of idx_o
module rr_pick
  import timeout_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DefaultNumReq,
  localparam int unsigned IdxW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  int unsigned cand;

  // Scan from the pointer upward, first hit wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      if (!valid_o && req_i[IdxW'(cand)]) begin
        valid_o                 = 1'b1;
        idx_o                   = IdxW'(cand);
        onehot_o[IdxW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timeout_arbiter.sv
// Shares one down-counting timer between NUM_REQ requesters, round-robin.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_i          : per-requester level request (drop to cancel)
//   cycles_i       : per-requester timeout length, sampled at grant
//   abort_i        : cancel the running timeout
//   gnt_o          : one-hot owner during COUNT and DONE
//   busy_o         : state is not IDLE
//   expired_o      : one-cycle pulse on the owner's bit at expiry
//   remaining_o    : current counter value
//   active_idx_o   : owner index
module timeout_arbiter
  import timeout_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DefaultNumReq,
  parameter  int unsigned WIDTH   = 16,
  localparam int unsigned IdxW    = idx_width(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]  cycles_i,
  input  logic                           abort_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic                           busy_o,
  output logic [NUM_REQ-1:0]             expired_o,
  output logic [WIDTH-1:0]               remaining_o,
  output logic [IdxW-1:0]                active_idx_o
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   exp_q, exp_d;
  logic                 busy_q, busy_d;

  logic                 pick_valid;
  logic [IdxW-1:0]      pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Next state; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    exp_d   = '0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          cnt_d   = cycles_i[pick_idx];
          ptr_d   = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IdxW'(1);
          state_d = (cycles_i[pick_idx] == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        // abort and request drop both outrank expiry
        if (abort_i || !req_i[idx_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WIDTH'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d != IDLE) begin
      busy_d         = 1'b1;
      gnt_d[idx_d]   = 1'b1;
    end
    if (state_d == DONE) begin
      exp_d[idx_d]   = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign busy_o       = busy_q;
  assign expired_o    = exp_q;
  assign remaining_o  = cnt_q;
  assign active_idx_o = idx_q;

endmodule

// File: tb/tb_timeout_arbiter.sv
// Directed bench for timeout_arbiter (NUM_REQ=4, WIDTH=16).
module tb_timeout_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][15:0] cycles;
  logic             abort;
  logic [3:0]       gnt;
  logic             busy;
  logic [3:0]       expired;
  logic [15:0]      remaining;
  logic [1:0]       active_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  timeout_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .cycles_i     (cycles),
    .abort_i      (abort),
    .gnt_o        (gnt),
    .busy_o       (busy),
    .expired_o    (expired),
    .remaining_o  (remaining),
    .active_idx_o (active_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({gnt, expired, busy, remaining, active_idx} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset: gnt=%b exp=%b busy=%b rem=%0d idx=%0d want all zero",
               gnt, expired, busy, remaining, active_idx);
    end
  endtask

  task automatic test_basic();
    logic [15:0] want_rem [4];
    want_rem = '{16'd3, 16'd2, 16'd1, 16'd0};
    cycles[0] = 16'd3;
    req = 4'b0001;
    tick();  // grant edge t -> now cycle t+1
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (gnt !== 4'b0001 || remaining !== want_rem[k] || busy !== 1'b1 ||
          expired !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL basic[%0d]: gnt=%b rem=%0d busy=%b exp=%b want gnt=0001 rem=%0d busy=1 exp=%b",
                 k, gnt, remaining, busy, expired, want_rem[k], (k == 3) ? 4'b0001 : 4'b0000);
      end
      if (k == 3) req = 4'b0000;
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || expired !== 4'b0000) begin
      tests_failed++;
      $display("FAIL basic_idle: busy=%b gnt=%b exp=%b want 0/0000/0000", busy, gnt, expired);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cycles = {16'd1, 16'd1, 16'd1, 16'd1};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      tests_run++;
      if (gnt !== oh || active_idx !== 2'(k % 4) || remaining !== 16'd1 || expired !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: gnt=%b idx=%0d rem=%0d exp=%b want gnt=%b idx=%0d rem=1 exp=0000",
                 k, gnt, active_idx, remaining, expired, oh, k % 4);
      end
      tick();
      tests_run++;
      if (expired !== oh || gnt !== oh) begin
        tests_failed++;
        $display("FAIL rr_expire[%0d]: exp=%b gnt=%b want %b", k, expired, gnt, oh);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0 || gnt !== 4'b0000 || expired !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rr_idle[%0d]: busy=%b gnt=%b exp=%b want idle", k, busy, gnt, expired);
      end
      if (k == 4) req = 4'b0000;
    end
  endtask

  task automatic test_zero_len();
    cycles[2] = 16'd0;
    req = 4'b0100;
    tick();
    tests_run++;
    if (expired !== 4'b0100 || gnt !== 4'b0100 || remaining !== 16'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_len: exp=%b gnt=%b rem=%0d busy=%b want 0100/0100/0/1",
               expired, gnt, remaining, busy);
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (busy !== 1'b0 || expired !== 4'b0000) begin
      tests_failed++;
      $display("FAIL zero_len_idle: busy=%b exp=%b want 0/0000", busy, expired);
    end
  endtask

  // use_abort=1 cancels with abort_i, otherwise by dropping the request
  task automatic test_cancel(input bit use_abort);
    bit seen_exp;
    seen_exp = 1'b0;
    cycles[1] = 16'd10;
    req = 4'b0010;
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || remaining !== 16'd10) begin
      tests_failed++;
      $display("FAIL cancel_grant(abort=%0d): gnt=%b rem=%0d want 0010/10", use_abort, gnt, remaining);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (expired !== 4'b0000) seen_exp = 1'b1;
    end
    tests_run++;
    if (remaining !== 16'd5) begin
      tests_failed++;
      $display("FAIL cancel_rem5(abort=%0d): rem=%0d want 5", use_abort, remaining);
    end
    if (use_abort) abort = 1'b1;
    else req = 4'b0000;
    tick();
    abort = 1'b0;
    req = 4'b0000;
    if (expired !== 4'b0000) seen_exp = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL cancel_idle(abort=%0d): busy=%b gnt=%b want 0/0000", use_abort, busy, gnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (expired !== 4'b0000) seen_exp = 1'b1;
    end
    tests_run++;
    if (seen_exp !== 1'b0) begin
      tests_failed++;
      $display("FAIL cancel_noexp(abort=%0d): expiry seen=1 want 0", use_abort);
    end
  endtask

  task automatic test_abort_at_one();
    cycles[3] = 16'd4;
    req = 4'b1000;
    for (int k = 0; k < 4; k++) tick();
    tests_run++;
    if (remaining !== 16'd1 || gnt !== 4'b1000) begin
      tests_failed++;
      $display("FAIL abort1_rem: rem=%0d gnt=%b want 1/1000", remaining, gnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    req = 4'b0000;
    tests_run++;
    if (busy !== 1'b0 || expired !== 4'b0000 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort1_noexp: busy=%b exp=%b gnt=%b want 0/0000/0000", busy, expired, gnt);
    end
    tick();
    tests_run++;
    if (expired !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort1_late: exp=%b want 0000", expired);
    end
  endtask

  task automatic test_reset_abort();
    cycles[2] = 16'd5;
    req = 4'b0100;
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0100 || remaining !== 16'd4) begin
      tests_failed++;
      $display("FAIL rstab_run: gnt=%b rem=%0d want 0100/4", gnt, remaining);
    end
    rst = 1'b1;
    abort = 1'b1;
    tick();
    rst = 1'b0;
    abort = 1'b0;
    tests_run++;
    if ({gnt, expired, busy, remaining, active_idx} !== 27'd0) begin
      tests_failed++;
      $display("FAIL rstab_outputs: gnt=%b exp=%b busy=%b rem=%0d idx=%0d want all zero",
               gnt, expired, busy, remaining, active_idx);
    end
    // pointer back at 0: requester 0 must beat requester 3
    cycles[0] = 16'd2;
    cycles[3] = 16'd2;
    req = 4'b1001;
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || active_idx !== 2'd0 || remaining !== 16'd2) begin
      tests_failed++;
      $display("FAIL rstab_ptr: gnt=%b idx=%0d rem=%0d want 0001/0/2", gnt, active_idx, remaining);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_cycles_change();
    cycles[1] = 16'd2;
    req = 4'b0010;
    tick();
    cycles[1] = 16'd9;
    tick();
    tests_run++;
    if (remaining !== 16'd1) begin
      tests_failed++;
      $display("FAIL cyc_change: rem=%0d want 1", remaining);
    end
    tick();
    tests_run++;
    if (expired !== 4'b0010) begin
      tests_failed++;
      $display("FAIL cyc_change_exp: exp=%b want 0010", expired);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    cycles = '0;
    abort  = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_len();
    test_cancel(1'b1);
    test_cancel(1'b0);
    test_abort_at_one();
    test_reset_abort();
    test_cycles_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/timeout_arbiter.md
Name: timeout_arbiter

Overview:
- Shares one down-counting timer between NUM_REQ requesters.
- Requesters assert a request with a programmed cycle count. The block grants round-robin, loads the shared counter, counts down, and pulses expiry to the granted requester.
- Sits beside the generic up/down counter blocks.
- Acts as the scheduler used by watchdog/timeout logic in bus adapters.

Parameters:
- NUM_REQ, 4: number of requesters, at least 2.
- WIDTH, 16: timeout counter width in bits.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset. One clock; reset is synchronous and active-high.
- req_i, input, NUM_REQ: per-requester timeout request, level. Held until expired_o, or dropped to cancel.
- cycles_i, input, NUM_REQ x WIDTH: per-requester timeout length. Sampled only at grant.
- abort_i, input, 1: global cancel of the running timeout.
- gnt_o, output, NUM_REQ: one-hot. Marks the requester owning the timer during COUNT and DONE.
- busy_o, output, 1: high whenever state is not IDLE.
- expired_o, output, NUM_REQ: one-cycle pulse on the owner's bit when its timeout elapses.
- remaining_o, output, WIDTH: current counter value.
- active_idx_o, output, $clog2(NUM_REQ): index of the owner. Valid while busy_o is high.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state goes to IDLE.
  - gnt_o=0, expired_o=0, busy_o=0, remaining_o=0, active_idx_o=0.
  - Round-robin pointer=0, so requester 0 has top priority first.
  - Reset mid-count drops the timeout silently; no expiry pulse.
- FSM states are IDLE, COUNT and DONE. All outputs are registered.
- IDLE, at edge t with some req_i bit set:
  - Pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register the owner index and load counter = cycles_i[owner]. Pointer becomes owner+1 mod NUM_REQ.
  - If the loaded value is 0, go to DONE; otherwise go to COUNT.
- COUNT:
  - Counter decrements by 1 per cycle. gnt_o[owner]=1.
  - When counter==1, the next state is DONE with counter=0.
- DONE:
  - expired_o[owner]=1 for exactly this cycle. gnt_o stays held.
  - Next state is IDLE.
- Timing for length N≥1 granted at edge t:
  - gnt_o high in cycles t+1 through t+N+1.
  - remaining_o reads N, N-1, … 1, then 0.
  - expired_o pulses in cycle t+N+1.
  - For N=0, DONE (with expiry) occurs in cycle t+1.
- Back-to-back: after DONE there is always one IDLE cycle, so the next grant appears at earliest t+N+3.
- Cancel during COUNT: abort_i=1, or req_i[owner]=0, sends the FSM to IDLE next cycle.
  - No expiry pulse; gnt_o and busy_o clear.
  - The pointer keeps its advanced value.
- Cancel in DONE is ignored; the expiry pulse still fires.
- Precedence when events coincide: rst_i > abort_i > drop of req_i[owner] > counter expiry.
- Requests from non-owners are ignored while busy and wait. Starvation-free: any held request is granted within NUM_REQ grants.
- cycles_i changes after grant have no effect on the running timeout.
- The counter never wraps; underflow below 0 is impossible by construction.

Decomposition:
- Package timeout_arbiter_pkg holds:
  - the state enum typedef (IDLE, COUNT, DONE);
  - the localparam computing the index width, $clog2(NUM_REQ) with minimum 1.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: valid, index, one-hot.
  - Parameterised by NUM_REQ.
- The counter register is implemented inline with synchronous reset.

Test Plan:
- Reset, then req_i=0001 with cycles_i[0]=3 asserted at edge t:
  - gnt_o=0001 in cycles t+1 to t+4.
  - remaining_o reads 3,2,1,0.
  - expired_o=0001 only in cycle t+4; busy_o=0 in cycle t+5.
- Round-robin: req_i=1111 held, all cycles_i=1:
  - Grant order 0,1,2,3,0.
  - Each expiry pulse is followed by one IDLE cycle.
- Zero length: cycles_i[2]=0, req_i=0100:
  - expired_o=0100 in the cycle right after grant.
  - No COUNT cycle occurs.
- Cancel:
  - cycles_i[1]=10, abort_i pulsed when remaining_o=5 → IDLE next cycle, expired_o never asserted.
  - Repeat with req_i[1] dropped instead; same result.
- Simultaneous events:
  - abort_i asserted in the cycle where remaining_o=1 → no expiry.
  - rst_i and abort_i together mid-count → all outputs at reset values next cycle, pointer back to 0.
